alu_arbiter: RTL

- Shares the single-cycle combinational ALU between two requesters: fetch/execute path (port 0) and address-generation/debug path (port 1).
- Accepts requests on valid/ready handshakes and arbitrates round-robin.
- Drives the ALU from registered operands, captures result and flags into a holding register, and returns them on a tagged response handshake.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: control encodings, flag positions
// and the arbiter state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b0001;
    localparam logic [3:0] ALU_AND      = 4'b0010;
    localparam logic [3:0] ALU_OR       = 4'b0011;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_NOT      = 4'b0101;
    localparam logic [3:0] ALU_SLL      = 4'b0110;
    localparam logic [3:0] ALU_SRL      = 4'b0111;
    localparam logic [3:0] ALU_MOV      = 4'b1000;
    localparam logic [3:0] ALU_CTRL_MAX = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic ctrl_illegal(input logic [3:0] ctrl);
        return ctrl > ALU_CTRL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin request
// accept, one registered execute cycle, then a held tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [3:0]       req_ctrl0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_ctrl1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    arb_state_t       state, state_nxt;
    logic             last_grant;
    logic [1:0]       grant;
    logic             op_id;
    logic             op_err;
    logic             req_fire;
    logic             rsp_fire;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [3:0]       sel_ctrl;

    rr_arb2 u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_a    = grant[1] ? req_a1    : req_a0;
    assign sel_b    = grant[1] ? req_b1    : req_b0;
    assign sel_ctrl = grant[1] ? req_ctrl1 : req_ctrl0;
    assign req_fire = |req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // req_ready is masked by rst_n so it reads zero while reset is held
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst_n) req_ready = grant;
                if (rst_n && (grant != 2'b00)) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The operand registers are the ALU drive, so the ALU inputs hold between ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_ADD;
            op_id       <= 1'b0;
            op_err      <= 1'b0;
            last_grant  <= 1'b1;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= 4'b0000;
            rsp_err     <= 1'b0;
            op_count    <= '0;
        end else begin
            if (req_fire) begin
                alu_a       <= sel_a;
                alu_b       <= sel_b;
                alu_control <= ctrl_illegal(sel_ctrl) ? ALU_ADD : sel_ctrl;
                op_err      <= ctrl_illegal(sel_ctrl);
                op_id       <= grant[1];
                last_grant  <= grant[1];
            end
            if (state == EXEC) begin
                rsp_id     <= op_id;
                rsp_err    <= op_err;
                rsp_result <= op_err ? '0 : alu_result;
                rsp_flags  <= op_err ? 4'b0000 : alu_flags;
            end
            if (rsp_fire) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
